// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the Newton-Raphson divider and its residual checker.
// Holds the Q-format constants, the checker FSM states and sign/magnitude helpers.
package fxp_pkg;

    localparam int FRAC_BITS = 16;
    localparam int DEF_TOL   = 64;
    localparam int MAX_W     = 64;
    localparam int WIDE_W    = 2 * MAX_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        RESID = 2'd2,
        DONE  = 2'd3
    } fxp_state_e;

    function automatic logic fxp_sign(input logic signed [WIDE_W-1:0] v);
        return v[WIDE_W-1];
    endfunction

    // Helpers take a sign-extended wide value so any operand width up to MAX_W can share them.
    function automatic logic [WIDE_W-1:0] fxp_abs(input logic signed [WIDE_W-1:0] v);
        return fxp_sign(v) ? WIDE_W'(-v) : WIDE_W'(v);
    endfunction

    function automatic logic fxp_within(input logic signed [WIDE_W-1:0] v,
                                        input logic [WIDE_W-1:0]        lim);
        return fxp_abs(v) <= lim;
    endfunction

endpackage

// File: rtl/fxp_shift_add_mul.sv
// Sequential radix-2 shift-add multiplier: unsigned (W+1)-bit multiplicand times W-bit multiplier.
// One multiplicand bit per cycle; done marks the cycle in which the final step is applied.
module fxp_shift_add_mul #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W:0]   mcand,
    input  logic [W-1:0] mplier,
    output logic         done,
    output logic [2*W:0] product
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W:0]       mcand_r;
    logic [W-1:0]     mplier_r;
    logic [2*W:0]     acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic             last_s;
    logic [2*W:0]     addend_s;

    // Bit W of the magnitude is only set for 2^W, which a signed W-bit quotient cannot produce.
    assign last_s   = run_r && (cnt_r == CNT_W'(W - 1));
    assign addend_s = {{(W + 1){1'b0}}, mplier_r} << cnt_r;

    // Operand latch and shift-add accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            run_r    <= 1'b0;
        end else if (start) begin
            mcand_r  <= mcand;
            mplier_r <= mplier;
            acc_r    <= '0;
            cnt_r    <= '0;
            run_r    <= 1'b1;
        end else if (run_r) begin
            if (mcand_r[cnt_r]) begin
                acc_r <= acc_r + addend_s;
            end
            cnt_r <= cnt_r + 1'b1;
            if (last_s) begin
                run_r <= 1'b0;
            end
        end
    end

    assign done    = last_s;
    assign product = acc_r;

endmodule

// File: rtl/fxp_div_residual_checker.sv
// Divider self-check: rebuilds numerator' = quotient*denom and flags
// |(numer << FRAC) - numerator'| <= TOL after a fixed W+2 cycle latency.
module fxp_div_residual_checker
    import fxp_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = FRAC_BITS,
    parameter int TOL  = DEF_TOL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          quotient,
    input  logic [W-1:0]          denom,
    input  logic [W-1:0]          numer,
    output logic                  busy,
    output logic                  done,
    output logic signed [2*W:0]   product,
    output logic signed [2*W+1:0] residual,
    output logic                  pass
);

    fxp_state_e state_r;
    fxp_state_e next_s;

    logic                  accept_s;
    logic [W:0]            q_ext_s;
    logic [W:0]            q_mag_s;
    logic                  mul_done_s;
    logic [2*W:0]          acc_s;
    logic signed [2*W:0]   prod_s;
    logic signed [2*W+1:0] numer_wide_s;
    logic signed [2*W+1:0] resid_s;

    logic                  sign_r;
    logic signed [W-1:0]   numer_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  pass_r;
    logic signed [2*W:0]   product_r;
    logic signed [2*W+1:0] residual_r;

    assign accept_s = (state_r == IDLE) && start;

    // One extra magnitude bit keeps the most negative quotient exact.
    assign q_ext_s = {quotient[W-1], quotient};
    assign q_mag_s = quotient[W-1] ? ({(W + 1){1'b0}} - q_ext_s) : q_ext_s;

    fxp_shift_add_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept_s),
        .mcand   (q_mag_s),
        .mplier  (denom),
        .done    (mul_done_s),
        .product (acc_s)
    );

    assign prod_s       = sign_r ? ({(2 * W + 1){1'b0}} - acc_s) : acc_s;
    assign numer_wide_s = (2 * W + 2)'(numer_r);
    assign resid_s      = (numer_wide_s <<< FRAC) - (2 * W + 2)'(prod_s);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_s = MULT;
                else       next_s = IDLE;
            end
            MULT: begin
                if (mul_done_s) next_s = RESID;
                else            next_s = MULT;
            end
            RESID:   next_s = DONE;
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Sign/numerator capture, result registers and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r     <= 1'b0;
            numer_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            product_r  <= '0;
            residual_r <= '0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                sign_r  <= quotient[W-1];
                numer_r <= numer;
                busy_r  <= 1'b1;
            end
            if (state_r == RESID) begin
                product_r  <= prod_s;
                residual_r <= resid_s;
                busy_r     <= 1'b0;
            end
            if (state_r == DONE) begin
                done_r <= 1'b1;
                pass_r <= fxp_within(WIDE_W'(residual_r), WIDE_W'(TOL));
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign product  = product_r;
    assign residual = residual_r;

endmodule

// File: tb/tb_fxp_div_residual_checker.sv
// Self-checking bench for fxp_div_residual_checker: vector table plus scoreboard of expected results,
// with hand-written sequences for busy-ignore, reset mid-multiply and back-to-back operation.
module tb_fxp_div_residual_checker;

    localparam int W = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [W-1:0]          quotient;
    logic [W-1:0]          denom;
    logic [W-1:0]          numer;
    logic                  busy;
    logic                  done;
    logic signed [2*W:0]   product;
    logic signed [2*W+1:0] residual;
    logic                  pass;

    always #5 clk = ~clk;

    fxp_div_residual_checker #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .quotient (quotient),
        .denom    (denom),
        .numer    (numer),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .residual (residual),
        .pass     (pass)
    );

    typedef struct {
        logic [31:0]        q;
        logic [31:0]        d;
        logic [31:0]        n;
        logic signed [64:0] p;
        logic signed [65:0] r;
        logic               ok;
    } vec_t;

    typedef struct {
        logic signed [64:0] p;
        logic signed [65:0] r;
        logic               ok;
        int                 cyc;
    } sb_t;

    vec_t tbl [0:13];
    sb_t  sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [65:0] act, input logic signed [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t model(input logic [31:0] q, input logic [31:0] d, input logic [31:0] n);
        vec_t v;
        logic signed [65:0] qs, ds, ns, pp;
        qs = {{34{q[31]}}, q};
        ds = {34'd0, d};
        ns = {{34{n[31]}}, n};
        pp = qs * ds;
        v.q  = q;
        v.d  = d;
        v.n  = n;
        v.p  = 65'(pp);
        v.r  = (ns <<< 16) - pp;
        v.ok = (v.r >= -66'sd64) && (v.r <= 66'sd64);
        return v;
    endfunction

    // Called at a negedge; start is sampled on the following posedge.
    task automatic drive_start(input vec_t v, input bit push);
        sb_t e;
        quotient = v.q;
        denom    = v.d;
        numer    = v.n;
        start    = 1'b1;
        if (push) begin
            e.p   = v.p;
            e.r   = v.r;
            e.ok  = v.ok;
            e.cyc = cyc + 1 + W + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) chk("busy_after_start", busy, 66'sd1);
    endtask

    task automatic wait_done(input int budget);
        int c0;
        int k;
        c0 = done_cnt;
        k  = 0;
        while (done_cnt == c0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        n_checks++;
        if (done_cnt == c0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin : mon
        sb_t e;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 66'sd1, 66'sd0);
            end else begin
                e = sb.pop_front();
                chk("product", product, e.p);
                chk("residual", residual, e.r);
                chk("pass", pass, e.ok);
                chk("latency", cyc, e.cyc);
                chk("busy_at_done", busy, 66'sd0);
            end
        end
    end

    initial begin
        int   d0;
        vec_t v2;
        rst      = 1'b1;
        start    = 1'b0;
        quotient = '0;
        denom    = '0;
        numer    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 66'sd0);
        chk("rst_done", done, 66'sd0);
        chk("rst_pass", pass, 66'sd0);
        chk("rst_product", product, 66'sd0);
        chk("rst_residual", residual, 66'sd0);

        tbl[0]  = '{q: 32'd42741, d: 32'd23, n: 32'd15, p: 65'sd983043, r: -66'sd3, ok: 1'b1};
        tbl[1]  = '{q: -32'sd42741, d: 32'd23, n: -32'sd15, p: -65'sd983043, r: 66'sd3, ok: 1'b1};
        tbl[2]  = '{q: 32'd65536, d: 32'd3, n: 32'd2, p: 65'sd196608, r: -66'sd65536, ok: 1'b0};
        tbl[3]  = '{q: 32'd12345, d: 32'd0, n: 32'd0, p: 65'sd0, r: 66'sd0, ok: 1'b1};
        tbl[4]  = '{q: 32'd12345, d: 32'd0, n: 32'd1, p: 65'sd0, r: 66'sd65536, ok: 1'b0};
        tbl[5]  = '{q: 32'd0, d: 32'd1000, n: 32'd0, p: 65'sd0, r: 66'sd0, ok: 1'b1};
        tbl[6]  = '{q: 32'd65472, d: 32'd1, n: 32'd1, p: 65'sd65472, r: 66'sd64, ok: 1'b1};
        tbl[7]  = '{q: 32'd65471, d: 32'd1, n: 32'd1, p: 65'sd65471, r: 66'sd65, ok: 1'b0};
        tbl[8]  = '{q: 32'd65600, d: 32'd1, n: 32'd1, p: 65'sd65600, r: -66'sd64, ok: 1'b1};
        tbl[9]  = '{q: 32'd65601, d: 32'd1, n: 32'd1, p: 65'sd65601, r: -66'sd65, ok: 1'b0};
        tbl[10] = '{q: 32'd0, d: 32'd7, n: 32'd1, p: 65'sd0, r: 66'sd65536, ok: 1'b0};
        tbl[11] = model(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        tbl[12] = model(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        tbl[13] = model($urandom, $urandom_range(1, 5000), $urandom);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive_start(tbl[i], 1'b1);
            wait_done(60);
        end
        repeat (5) @(negedge clk);
        chk("hold_product", product, tbl[13].p);

        // A second start during MULT must be dropped without disturbing the first operation.
        v2 = model(32'd65536, 32'd3, 32'd2);
        @(negedge clk);
        d0 = done_cnt;
        drive_start(tbl[0], 1'b1);
        repeat (3) @(negedge clk);
        drive_start(v2, 1'b0);
        wait_done(60);
        repeat (40) @(posedge clk);
        chk("single_done", done_cnt - d0, 66'sd1);

        // Reset in the middle of the multiply.
        @(negedge clk);
        drive_start(tbl[2], 1'b0);
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 66'sd0);
        chk("midrst_done", done, 66'sd0);
        chk("midrst_pass", pass, 66'sd0);
        chk("midrst_product", product, 66'sd0);
        chk("midrst_residual", residual, 66'sd0);
        repeat (45) @(posedge clk);
        chk("midrst_no_done", done_cnt - d0, 66'sd0);

        @(negedge clk);
        drive_start(tbl[1], 1'b1);
        wait_done(60);

        // Back-to-back: next start issued in the cycle done is high.
        @(negedge clk);
        drive_start(tbl[2], 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("b2b_done_seen", done, 66'sd1);
        drive_start(tbl[6], 1'b1);
        wait_done(60);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 66'sd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
